// File: rtl/masked_refresh_buffer.sv
`timescale 1ns/1ps
// Refreshes count d-share Boolean sharings with fresh randomness and queues them in a 2-deep elastic FIFO.
// Push-to-out_valid latency 1 cycle; in_ready = occupancy < 2 (registered); randomness consumed only on a push.
module masked_refresh_buffer #(
  parameter int d     = 2,
  parameter int count = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [count*d-1:0]     in_sh,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [count*(d-1)-1:0] rnd,
  input  logic                   rnd_valid,
  output logic                   rnd_ready,
  output logic [count*d-1:0]     out_sh,
  output logic                   out_valid,
  input  logic                   out_ready
);
  localparam int W = count * d;

  if (d < 2) begin : g_bad_d
    $error("masked_refresh_buffer: d must be >= 2");
  end

  logic [W-1:0] r_mem [2];
  logic         r_head;
  logic         r_tail;
  logic [1:0]   r_occ;
  logic         r_in_rdy;
  logic         r_out_vld;
  logic [W-1:0] r_out_sh;

  logic         w_push;
  logic         w_pop;
  logic [W-1:0] w_ref;
  logic [1:0]   w_occ_nxt;
  logic         w_head_nxt;
  logic [W-1:0] w_head_dat;

  // Each r_k masks share k and is folded into the last share, so the unmasked XOR is unchanged.
  always_comb begin
    w_ref = '0;
    for (int i = 0; i < count; i++) begin
      w_ref[i*d+d-1] = in_sh[i*d+d-1];
      for (int k = 0; k < d-1; k++) begin
        w_ref[i*d+k]   = in_sh[i*d+k] ^ rnd[i*(d-1)+k];
        w_ref[i*d+d-1] = w_ref[i*d+d-1] ^ rnd[i*(d-1)+k];
      end
    end
  end

  assign w_push    = in_valid & rnd_valid & r_in_rdy;
  assign w_pop     = r_out_vld & out_ready;
  assign rnd_ready = w_push;

  assign w_occ_nxt  = r_occ + {1'b0, w_push} - {1'b0, w_pop};
  assign w_head_nxt = r_head ^ w_pop;
  // Next head may be the entry being written this cycle (empty buffer, or push+pop at occupancy 1).
  assign w_head_dat = (w_push && (r_tail == w_head_nxt)) ? w_ref : r_mem[w_head_nxt];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0]  <= '0;
      r_mem[1]  <= '0;
      r_head    <= 1'b0;
      r_tail    <= 1'b0;
      r_occ     <= 2'd0;
      r_in_rdy  <= 1'b0;
      r_out_vld <= 1'b0;
      r_out_sh  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= w_ref;
      end
      r_head    <= w_head_nxt;
      r_tail    <= r_tail ^ w_push;
      r_occ     <= w_occ_nxt;
      r_in_rdy  <= (w_occ_nxt != 2'd2);
      r_out_vld <= (w_occ_nxt != 2'd0);
      r_out_sh  <= w_head_dat;
    end
  end

  assign in_ready  = r_in_rdy;
  assign out_valid = r_out_vld;
  assign out_sh    = r_out_sh;

endmodule

// File: tb/tb_masked_refresh_buffer.sv
`timescale 1ns/1ps
// Scoreboard bench: d=2/count=2 instance for directed scenarios, d=4/count=3 instance for a random sweep.
module tb_masked_refresh_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  in_sh2 = '0;
  logic        in_valid2 = 1'b0, rnd_valid2 = 1'b0, out_ready2 = 1'b0;
  logic [1:0]  rnd2 = '0;
  logic        in_ready2, rnd_ready2, out_valid2;
  logic [3:0]  out_sh2;

  logic [11:0] in_sh4 = '0;
  logic        in_valid4 = 1'b0, rnd_valid4 = 1'b0, out_ready4 = 1'b0;
  logic [8:0]  rnd4 = '0;
  logic        in_ready4, rnd_ready4, out_valid4;
  logic [11:0] out_sh4;

  masked_refresh_buffer #(.d(2), .count(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_sh(in_sh2), .in_valid(in_valid2), .in_ready(in_ready2),
    .rnd(rnd2), .rnd_valid(rnd_valid2), .rnd_ready(rnd_ready2),
    .out_sh(out_sh2), .out_valid(out_valid2), .out_ready(out_ready2)
  );

  masked_refresh_buffer #(.d(4), .count(3)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_sh(in_sh4), .in_valid(in_valid4), .in_ready(in_ready4),
    .rnd(rnd4), .rnd_valid(rnd_valid4), .rnd_ready(rnd_ready4),
    .out_sh(out_sh4), .out_valid(out_valid4), .out_ready(out_ready4)
  );

  int errors = 0;
  int checks = 0;
  logic [3:0] q2[$];
  logic [2:0] q4[$];
  int m2_occ = 0;
  int n_pop2 = 0;

  // For d=2 every sharing's single random bit flips both of its shares.
  function automatic logic [3:0] ref2(input logic [3:0] sh, input logic [1:0] r);
    ref2 = sh ^ {r[1], r[1], r[0], r[0]};
  endfunction

  function automatic logic [2:0] xr4(input logic [11:0] v);
    logic [2:0] x;
    for (int i = 0; i < 3; i++) x[i] = ^v[i*4 +: 4];
    return x;
  endfunction

  // One clock cycle on the d=2 instance: drive at negedge, check, update the model, idle after posedge.
  task automatic step2(input logic iv, input logic [3:0] sh, input logic rv,
                       input logic [1:0] r, input logic ordy);
    logic exp_push, exp_pop;
    logic [3:0] exp_sh;
    @(negedge clk);
    in_valid2 = iv; in_sh2 = sh; rnd_valid2 = rv; rnd2 = r; out_ready2 = ordy;
    #1;
    exp_push = iv & rv & (m2_occ < 2);
    exp_pop  = ordy & (m2_occ > 0);
    checks++;
    if (out_valid2 !== (m2_occ > 0)) begin
      errors++; $display("FAIL out_valid2: got %b expected %b", out_valid2, (m2_occ > 0));
    end
    checks++;
    if (in_ready2 !== (m2_occ < 2)) begin
      errors++; $display("FAIL in_ready2: got %b expected %b", in_ready2, (m2_occ < 2));
    end
    checks++;
    if (rnd_ready2 !== exp_push) begin
      errors++; $display("FAIL rnd_ready2: got %b expected %b", rnd_ready2, exp_push);
    end
    if (exp_pop) begin
      checks++;
      if (q2.size() == 0) begin
        errors++; $display("FAIL scoreboard2: pop with empty queue");
      end else begin
        exp_sh = q2.pop_front();
        if (out_sh2 !== exp_sh) begin
          errors++; $display("FAIL out_sh2: got %b expected %b", out_sh2, exp_sh);
        end
      end
      n_pop2++;
    end
    if (exp_push) q2.push_back(ref2(sh, r));
    m2_occ = m2_occ + int'(exp_push) - int'(exp_pop);
    @(posedge clk);
    #1;
    in_valid2 = 1'b0; rnd_valid2 = 1'b0; out_ready2 = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (out_valid2 !== 1'b0 || out_sh2 !== 4'b0000 || in_ready2 !== 1'b0) begin
      errors++; $display("FAIL reset_state: got vld=%b sh=%b rdy=%b expected 0 0000 0", out_valid2, out_sh2, in_ready2);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready2 !== 1'b0) begin
      errors++; $display("FAIL ready_before_edge: got %b expected 0", in_ready2);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready2 !== 1'b1) begin
      errors++; $display("FAIL ready_after_edge: got %b expected 1", in_ready2);
    end
    step2(1'b1, 4'b1010, 1'b1, 2'b11, 1'b0);
    @(negedge clk); #1;
    checks++;
    if (out_valid2 !== 1'b1 || out_sh2 !== 4'b0101) begin
      errors++; $display("FAIL basic_refresh: got vld=%b sh=%b expected 1 0101", out_valid2, out_sh2);
    end
    checks++;
    if ({^out_sh2[3:2], ^out_sh2[1:0]} !== 2'b11) begin
      errors++; $display("FAIL basic_unmasked: got %b expected 11", {^out_sh2[3:2], ^out_sh2[1:0]});
    end
    step2(1'b0, 4'b0000, 1'b0, 2'b00, 1'b1);
  endtask

  task automatic test_rnd_stall();
    int p0;
    p0 = n_pop2;
    repeat (3) step2(1'b1, 4'b1001, 1'b0, 2'b10, 1'b1);
    step2(1'b1, 4'b1001, 1'b1, 2'b10, 1'b1);
    repeat (2) step2(1'b0, 4'b0000, 1'b0, 2'b00, 1'b1);
    checks++;
    if (n_pop2 - p0 != 1) begin
      errors++; $display("FAIL stall_outputs: got %0d expected 1", n_pop2 - p0);
    end
  endtask

  task automatic test_fill();
    step2(1'b1, 4'b0110, 1'b1, 2'b01, 1'b0);
    step2(1'b1, 4'b1111, 1'b1, 2'b10, 1'b0);
    step2(1'b1, 4'b0001, 1'b1, 2'b11, 1'b0);
    checks++;
    if (m2_occ != 2 || q2.size() != 2) begin
      errors++; $display("FAIL fill_level: got %0d expected 2", q2.size());
    end
    repeat (3) step2(1'b0, 4'b0000, 1'b0, 2'b00, 1'b1);
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = n_pop2;
    for (int i = 0; i < 8; i++)
      step2(1'b1, 4'(i * 5 + 3), 1'b1, 2'($urandom_range(0, 3)), 1'b1);
    checks++;
    if (n_pop2 - p0 != 7) begin
      errors++; $display("FAIL b2b_streaming: got %0d expected 7", n_pop2 - p0);
    end
    step2(1'b0, 4'b0000, 1'b0, 2'b00, 1'b1);
    checks++;
    if (n_pop2 - p0 != 8) begin
      errors++; $display("FAIL b2b_total: got %0d expected 8", n_pop2 - p0);
    end
  endtask

  task automatic test_mid_reset();
    step2(1'b1, 4'b1100, 1'b1, 2'b01, 1'b0);
    step2(1'b1, 4'b0011, 1'b1, 2'b10, 1'b0);
    @(negedge clk); #1;
    in_valid2 = 1'b1; rnd_valid2 = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid2 !== 1'b0 || out_sh2 !== 4'b0000 || in_ready2 !== 1'b0 || rnd_ready2 !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got vld=%b sh=%b rdy=%b rr=%b expected 0 0000 0 0",
                         out_valid2, out_sh2, in_ready2, rnd_ready2);
    end
    in_valid2 = 1'b0; rnd_valid2 = 1'b0;
    #1 rst_n = 1'b1;
    q2.delete();
    m2_occ = 0;
    repeat (3) step2(1'b0, 4'b0000, 1'b0, 2'b00, 1'b1);
    step2(1'b1, 4'b1000, 1'b1, 2'b01, 1'b1);
    step2(1'b0, 4'b0000, 1'b0, 2'b00, 1'b1);
  endtask

  task automatic test_sweep4();
    int m4_occ = 0, pulses = 0, accepted = 0, pops = 0;
    logic exp_push, exp_pop;
    logic [2:0] exp_x;
    for (int n = 0; n < 1010; n++) begin
      @(negedge clk);
      in_valid4  = (n < 1000) && ($urandom_range(0, 3) != 0);
      rnd_valid4 = (n < 1000) && ($urandom_range(0, 3) != 0);
      out_ready4 = (n >= 1000) || ($urandom_range(0, 3) != 0);
      in_sh4 = 12'($urandom);
      rnd4   = 9'($urandom);
      #1;
      exp_push = in_valid4 & rnd_valid4 & (m4_occ < 2);
      exp_pop  = out_ready4 & (m4_occ > 0);
      checks++;
      if (rnd_ready4 !== exp_push) begin
        errors++; $display("FAIL sweep_rnd_ready n=%0d: got %b expected %b", n, rnd_ready4, exp_push);
      end
      checks++;
      if (out_valid4 !== (m4_occ > 0) || in_ready4 !== (m4_occ < 2)) begin
        errors++; $display("FAIL sweep_flags n=%0d: got vld=%b rdy=%b expected occ=%0d", n, out_valid4, in_ready4, m4_occ);
      end
      if (rnd_ready4 === 1'b1) pulses++;
      if (exp_pop) begin
        checks++;
        exp_x = (q4.size() != 0) ? q4.pop_front() : 3'bxxx;
        if (xr4(out_sh4) !== exp_x) begin
          errors++; $display("FAIL sweep_unmasked n=%0d: got %b expected %b", n, xr4(out_sh4), exp_x);
        end
        pops++;
      end
      if (exp_push) begin
        q4.push_back(xr4(in_sh4));
        accepted++;
      end
      m4_occ = m4_occ + int'(exp_push) - int'(exp_pop);
      @(posedge clk);
    end
    in_valid4 = 1'b0; rnd_valid4 = 1'b0;
    checks++;
    if (pulses != accepted || pops != accepted || q4.size() != 0) begin
      errors++; $display("FAIL sweep_totals: got pulses=%0d pops=%0d left=%0d expected %0d %0d 0",
                         pulses, pops, q4.size(), accepted, accepted);
    end
  endtask

  initial begin
    test_reset();
    test_rnd_stall();
    test_fill();
    test_back_to_back();
    test_mid_reset();
    test_sweep4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
